action_scheduler: RTL and testbench

Sequences player and gravity actions into the tetris game engine. It collects one-cycle action pulses from two requesters (push-button action generators and the EPP host link) and an internal gravity timer, and coalesces duplicate requests. It then issues exactly one command at a time over a valid/ready handshake, with a fixed priority order and a settle gap after each command. It sits between the action generators and the game engine, replacing the direct OR-ing of sources.

---
 rtl/action_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_action_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_scheduler.sv
// action_scheduler: merges button, EPP and gravity action pulses into a
// pending mask, coalesces duplicates, and issues one command at a time over
// a valid/ready handshake with fixed priority and a post-accept holdoff gap.
// Optional build macro: ACTION_SCHED_STATS_EN enables the coalesce counter;
// when undefined, coalesce_cnt is tied to zero.
module action_scheduler #(
  parameter int unsigned GRAVITY_DIV = 25000000,
  parameter int unsigned HOLDOFF_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_req,
  input  logic [5:0] epp_req,
  input  logic       gravity_en,
  input  logic [2:0] speed,
  input  logic       pause,
  input  logic       flush,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [5:0] pending,
  output logic       busy,
  output logic [7:0] coalesce_cnt
);

  localparam int unsigned GW = $clog2(GRAVITY_DIV + 1);
  localparam int unsigned HW = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    r_state;
  logic          r_valid;
  logic [2:0]    r_code;
  logic [5:0]    r_pending;
  logic          r_busy;
  logic [HW-1:0] r_hcnt;
  logic [GW-1:0] r_grav;
  logic          r_dman;   // pending DOWN includes a manual (non-gravity) request
  logic          r_rstg;   // command in flight restarts gravity when accepted

  logic [1:0]    w_state_nxt;
  logic          w_valid_nxt;
  logic [2:0]    w_code_nxt;
  logic [5:0]    w_pend_nxt;
  logic [HW-1:0] w_hcnt_nxt;
  logic [GW-1:0] w_grav_nxt;
  logic          w_dman_nxt;
  logic          w_rstg_nxt;
  logic          w_tick;
  logic [5:0]    w_new;
  logic [5:0]    w_onehot;
  logic [2:0]    w_code;
  logic          w_grant;
  logic [5:0]    w_clr;
  logic          w_accept;
  logic [GW-1:0] w_last;

  // Terminal gravity count for the current speed setting
  assign w_last = GW'((GRAVITY_DIV >> speed) - 32'd1);

  // State register; all outputs come straight from these flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_code    <= 3'd0;
      r_pending <= 6'd0;
      r_busy    <= 1'b0;
      r_hcnt    <= '0;
      r_grav    <= '0;
      r_dman    <= 1'b0;
      r_rstg    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_code    <= w_code_nxt;
      r_pending <= w_pend_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_hcnt    <= w_hcnt_nxt;
      r_grav    <= w_grav_nxt;
      r_dman    <= w_dman_nxt;
      r_rstg    <= w_rstg_nxt;
    end
  end

  // Request merge, priority grant, gravity timer and FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_code_nxt  = r_code;
    w_hcnt_nxt  = r_hcnt;
    w_rstg_nxt  = r_rstg;
    w_grav_nxt  = r_grav;
    w_onehot    = 6'd0;
    w_code      = 3'd0;
    w_new       = 6'd0;

    w_tick = gravity_en && !pause && (r_grav >= w_last);
    if (!flush) begin
      w_new = btn_req | epp_req | (w_tick ? 6'b000100 : 6'b000000);
    end

    // DROP > ROT_R > ROT_L > LEFT > RIGHT > DOWN
    if (r_pending[3]) begin
      w_onehot = 6'b001000; w_code = 3'd4;
    end else if (r_pending[4]) begin
      w_onehot = 6'b010000; w_code = 3'd5;
    end else if (r_pending[5]) begin
      w_onehot = 6'b100000; w_code = 3'd6;
    end else if (r_pending[0]) begin
      w_onehot = 6'b000001; w_code = 3'd1;
    end else if (r_pending[1]) begin
      w_onehot = 6'b000010; w_code = 3'd2;
    end else if (r_pending[2]) begin
      w_onehot = 6'b000100; w_code = 3'd3;
    end

    w_grant  = (r_state == S_IDLE) && (r_pending != 6'd0) && !pause && !flush;
    w_clr    = w_grant ? w_onehot : 6'd0;
    w_accept = (r_state == S_ISSUE) && cmd_ready;

    w_pend_nxt = (r_pending & ~w_clr) | w_new;
    w_dman_nxt = (r_dman & ~w_clr[2]) | (w_new[2] & (btn_req[2] | epp_req[2]));

    // Manual DOWN/DROP restarts gravity; gravity-generated DOWN does not
    if (w_accept && r_rstg) begin
      w_grav_nxt = '0;
    end else if (gravity_en && !pause) begin
      w_grav_nxt = w_tick ? '0 : r_grav + GW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
          w_valid_nxt = 1'b1;
          w_code_nxt  = w_code;
          w_rstg_nxt  = w_onehot[3] | (w_onehot[2] & r_dman);
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          w_valid_nxt = 1'b0;
          w_code_nxt  = 3'd0;
          w_rstg_nxt  = 1'b0;
          if (HOLDOFF_CYC == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
            w_hcnt_nxt  = HW'(HOLDOFF_CYC);
          end
        end
      end
      S_HOLD: begin
        if (r_hcnt <= HW'(1)) begin
          w_state_nxt = S_IDLE;
          w_hcnt_nxt  = '0;
        end else begin
          w_hcnt_nxt = r_hcnt - HW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (flush) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_code_nxt  = 3'd0;
      w_hcnt_nxt  = '0;
      w_pend_nxt  = 6'd0;
      w_dman_nxt  = 1'b0;
      w_rstg_nxt  = 1'b0;
      w_grav_nxt  = '0;
    end
  end

`ifdef ACTION_SCHED_STATS_EN
  logic [5:0] w_coal;
  logic [7:0] r_coal;

  assign w_coal = w_new & r_pending & ~w_clr;

  // Saturating count of cycles in which any request was absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coal <= 8'd0;
    end else if (flush) begin
      r_coal <= 8'd0;
    end else if ((w_coal != 6'd0) && (r_coal != 8'hFF)) begin
      r_coal <= r_coal + 8'd1;
    end
  end

  assign coalesce_cnt = r_coal;
`else
  assign coalesce_cnt = 8'd0;
`endif

  assign cmd_valid = r_valid;
  assign cmd_code  = r_code;
  assign pending   = r_pending;
  assign busy      = r_busy;

endmodule

// File: tb/tb_action_scheduler.sv
// Testbench for action_scheduler: directed vectors, expected command codes
// queued by the stimulus and popped by a monitor on each handshake.
module tb_action_scheduler;

`ifdef ACTION_SCHED_STATS_EN
  localparam int EXP_COAL = 2;
`else
  localparam int EXP_COAL = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] btn_req;
  logic [5:0] epp_req;
  logic       gravity_en;
  logic [2:0] speed;
  logic       pause;
  logic       flush;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [5:0] pending;
  logic       busy;
  logic [7:0] coalesce_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_q[$];
  int mon_e;

  action_scheduler #(.GRAVITY_DIV(128), .HOLDOFF_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_req(btn_req), .epp_req(epp_req),
    .gravity_en(gravity_en), .speed(speed), .pause(pause), .flush(flush),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .pending(pending), .busy(busy), .coalesce_cnt(coalesce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_valid: no cmd_valid within %0d cycles", bound);
    end
  endtask

  // Scoreboard monitor: every handshake must match the next queued code
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_unexpected: got code %0d expected none", cmd_code);
      end else begin
        mon_e = exp_q.pop_front();
        check("scoreboard_code", int'(cmd_code), mon_e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, bcnt, first, c0, k, td, tg, nr;
    int t[3];
    bit pv, ok;

    rst_n = 1'b0; btn_req = '0; epp_req = '0; gravity_en = 1'b0; speed = 3'd2;
    pause = 1'b0; flush = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_code", int'(cmd_code), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_coal", int'(coalesce_cnt), 0);
    step(); rst_n = 1'b1; step();

    // Single request: 2-cycle latency, one valid cycle, busy 1+holdoff
    cmd_ready = 1'b1; btn_req = 6'b000001; exp_q.push_back(1);
    step(); btn_req = '0;
    @(negedge clk);
    check("t1_pending", int'(pending), 1);
    check("t1_valid_early", int'(cmd_valid), 0);
    vcnt = 0; bcnt = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        vcnt++;
        if (first < 0) first = i;
      end
      if (busy) bcnt++;
    end
    check("t1_latency", first, 0);
    check("t1_valid_cycles", vcnt, 1);
    check("t1_busy_cycles", bcnt, 3);

    // Priority: DROP before LEFT
    step(); cmd_ready = 1'b0; btn_req = 6'b000001; epp_req = 6'b001000;
    exp_q.push_back(4); exp_q.push_back(1);
    step(); btn_req = '0; epp_req = '0;
    @(negedge clk);
    check("t2_pending_both", int'(pending), 9);
    step();
    @(negedge clk);
    check("t2_pending_after_grant", int'(pending), 1);
    check("t2_code_drop", int'(cmd_code), 4);
    step(); cmd_ready = 1'b1;
    @(negedge clk);
    step();
    wait_valid(10, ok);
    if (ok) check("t2_pending_final", int'(pending), 0);
    step();

    // Backpressure and coalescing under pause
    repeat (6) step();
    cmd_ready = 1'b0; pause = 1'b1; exp_q.push_back(5);
    for (int i = 0; i < 3; i++) begin
      btn_req = 6'b010000; step();
      btn_req = '0; step();
    end
    @(negedge clk);
    check("t3_pending", int'(pending), 16);
    check("t3_paused_valid", int'(cmd_valid), 0);
    check("t3_coal", int'(coalesce_cnt), EXP_COAL);
    step(); pause = 1'b0;
    step();
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_code == 3'd5) vcnt++;
    end
    check("t3_held_stable", vcnt, 4);
    check("t3_pending_cleared", int'(pending), 0);
    step(); cmd_ready = 1'b1;
    @(negedge clk);
    repeat (8) step();
    check("t3_no_second", int'(pending), 0);

    // Gravity: period 32 at speed 2, DROP restarts, pause halts
    speed = 3'd2;
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
    step(); gravity_en = 1'b1; c0 = cyc;
    nr = 0; pv = 1'b0;
    for (int i = 0; i < 200 && nr < 3; i++) begin
      @(negedge clk);
      if (cmd_valid && !pv) begin
        t[nr] = cyc;
        nr++;
      end
      pv = cmd_valid;
    end
    check("t4_rises", nr, 3);
    check("t4_first", t[0] - c0, 33);
    check("t4_gap1", t[1] - t[0], 32);
    check("t4_gap2", t[2] - t[1], 32);
    repeat (10) step();
    exp_q.push_back(4); exp_q.push_back(3);
    k = cyc; epp_req = 6'b001000;
    step(); epp_req = '0;
    td = -1; tg = -1; pv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid && !pv) begin
        if (cmd_code == 3'd4) td = cyc;
        else if (cmd_code == 3'd3) begin
          tg = cyc;
          break;
        end
      end
      pv = cmd_valid;
    end
    check("t4_drop_time", td - k, 2);
    check("t4_restart", tg - k, 36);
    step(); pause = 1'b1;
    nr = 0; pv = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cmd_valid && !pv) nr++;
      pv = cmd_valid;
    end
    check("t4_pause_rises", nr, 0);
    check("t4_pause_pending", int'(pending), 0);
    gravity_en = 1'b0; pause = 1'b0;
    step();

    // Flush mid-issue
    step(); cmd_ready = 1'b0; btn_req = 6'b101010;
    step(); btn_req = '0;
    step();
    @(negedge clk);
    check("t5_code", int'(cmd_code), 4);
    check("t5_pending", int'(pending), 34);
    step(); flush = 1'b1; btn_req = 6'b000001;
    step(); flush = 1'b0; btn_req = '0;
    @(negedge clk);
    check("t5_valid", int'(cmd_valid), 0);
    check("t5_code_zero", int'(cmd_code), 0);
    check("t5_pending_zero", int'(pending), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_coal", int'(coalesce_cnt), 0);
    repeat (5) step();
    check("t5_stays_idle", int'(cmd_valid) + int'(pending), 0);

    // Async reset mid-HOLDOFF
    step(); cmd_ready = 1'b1; exp_q.push_back(2); btn_req = 6'b000010;
    step(); btn_req = '0;
    step();
    @(negedge clk);
    step(); btn_req = 6'b000100;
    step(); btn_req = '0;
    @(negedge clk);
    check("t6_busy_hold", int'(busy), 1);
    check("t6_pending_down", int'(pending), 4);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_pending", int'(pending), 0);
    check("t6_rst_valid", int'(cmd_valid) + int'(cmd_code), 0);
    step(); step(); rst_n = 1'b1;
    step(); exp_q.push_back(1); btn_req = 6'b000001;
    step(); btn_req = '0;
    @(negedge clk);
    check("t6_latency_early", int'(cmd_valid), 0);
    @(negedge clk);
    check("t6_latency_valid", int'(cmd_valid), 1);
    repeat (8) step();
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
